// File: rtl/sqrt_pkg.sv
// Shared widths and types for the square-root datapath (sqrt_conv and its result collector).
package sqrt_pkg;
  localparam int unsigned ARG_W          = 8;
  localparam int unsigned RES_W          = 4;
  localparam int unsigned SQRT_RES_DEPTH = 4;

  typedef logic [ARG_W-1:0] arg_t;
  typedef logic [RES_W-1:0] res_t;
endpackage

// File: rtl/sqrt_res_ring.sv
// Ring buffer for square-root results: storage, head/tail pointers and occupancy.
module sqrt_res_ring
  import sqrt_pkg::*;
#(
  parameter int unsigned DEPTH = SQRT_RES_DEPTH,
  localparam int unsigned LW   = $clog2(DEPTH + 1),
  localparam int unsigned PW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  res_t          push_data,
  input  logic          pop,
  output res_t          head_data,
  output logic [LW-1:0] level
);

  res_t          mem [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;

  // Storage is deliberately left out of reset; level alone defines validity.
  always_ff @(posedge clk) begin
    if (push) mem[tail] <= push_data;
  end

  // DEPTH is a power of two, so natural pointer wrap gives modulo-DEPTH.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      level <= '0;
    end else begin
      if (push) tail <= tail + PW'(1);
      if (pop)  head <= head + PW'(1);
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  assign head_data = mem[head];

endmodule

// File: rtl/sqrt_res_collector.sv
// Buffers sqrt_conv results for a ready/valid consumer; sticky overflow on drops.
// Optional statistics (res_count, res_max) compiled in with SQRT_RES_STATS_EN.
module sqrt_res_collector
  import sqrt_pkg::*;
#(
  parameter int unsigned DEPTH = SQRT_RES_DEPTH
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         sqrt_valid,
  input  logic [3:0]                   sqrt_res,
  output logic                         out_valid,
  output logic [3:0]                   out_data,
  input  logic                         out_ready,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic                         overflow,
  input  logic                         clr_ovf,
  output logic [15:0]                  res_count,
  output logic [3:0]                   res_max
);

  localparam int unsigned LW = $clog2(DEPTH + 1);

  logic full;
  logic pop;
  logic push;
  logic drop;
  res_t head_data;

  assign full      = (level == LW'(DEPTH));
  assign out_valid = (level != '0);
  assign pop       = out_valid & out_ready;
  // A pop in the same cycle frees the slot, so a full buffer still accepts.
  assign push      = sqrt_valid & (~full | pop);
  assign drop      = sqrt_valid & full & ~pop;
  assign out_data  = out_valid ? head_data : '0;

  sqrt_res_ring #(
    .DEPTH (DEPTH)
  ) u_ring (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (sqrt_res),
    .pop       (pop),
    .head_data (head_data),
    .level     (level)
  );

  // A drop in the same cycle as clr_ovf wins so no loss goes unreported.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       overflow <= 1'b0;
    else if (drop)    overflow <= 1'b1;
    else if (clr_ovf) overflow <= 1'b0;
  end

`ifdef SQRT_RES_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      res_count <= '0;
      res_max   <= '0;
    end else if (push) begin
      if (res_count != '1)    res_count <= res_count + 16'd1;
      if (sqrt_res > res_max) res_max   <= sqrt_res;
    end
  end
`else
  assign res_count = '0;
  assign res_max   = '0;
`endif

endmodule

// File: tb/tb_sqrt_res_collector.sv
// Directed bench for sqrt_res_collector (DEPTH=4); stats expectations follow SQRT_RES_STATS_EN.
module tb_sqrt_res_collector;

`ifdef SQRT_RES_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        sqrt_valid;
  logic [3:0]  sqrt_res;
  logic        out_valid;
  logic [3:0]  out_data;
  logic        out_ready;
  logic [2:0]  level;
  logic        overflow;
  logic        clr_ovf;
  logic [15:0] res_count;
  logic [3:0]  res_max;

  int tests = 0;
  int fails = 0;

  sqrt_res_collector #(.DEPTH(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .sqrt_valid (sqrt_valid),
    .sqrt_res   (sqrt_res),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .level      (level),
    .overflow   (overflow),
    .clr_ovf    (clr_ovf),
    .res_count  (res_count),
    .res_max    (res_max)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; sqrt_valid = 1'b0; sqrt_res = '0; out_ready = 1'b0; clr_ovf = 1'b0;
    #3;
    check("rst_valid", 16'(out_valid), 16'd0);
    check("rst_level", 16'(level), 16'd0);
    check("rst_data", 16'(out_data), 16'd0);
    check("rst_ovf", 16'(overflow), 16'd0);
    check("rst_cnt", res_count, 16'd0);
    check("rst_max", 16'(res_max), 16'd0);
    step();
    reset = 1'b1;

    // Results of sqrt(9)=3 then sqrt(4)=2, consumer stalled.
    sqrt_valid = 1'b1; sqrt_res = 4'd3; step();
    check("lat_valid", 16'(out_valid), 16'd1);
    check("lat_data", 16'(out_data), 16'd3);
    sqrt_res = 4'd2; step();
    sqrt_valid = 1'b0;
    check("two_level", 16'(level), 16'd2);
    check("two_data", 16'(out_data), 16'd3);
    step();
    check("stall_hold", 16'(out_data), 16'd3);
    out_ready = 1'b1; step();
    check("pop1_data", 16'(out_data), 16'd2);
    check("pop1_level", 16'(level), 16'd1);
    step();
    check("pop2_level", 16'(level), 16'd0);
    check("pop2_valid", 16'(out_valid), 16'd0);
    out_ready = 1'b0;

    // Fresh start, fill then overflow.
    reset = 1'b0; #1; reset = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      sqrt_valid = 1'b1; sqrt_res = 4'(i); step();
    end
    sqrt_valid = 1'b0;
    check("ovf_set", 16'(overflow), 16'd1);
    check("ovf_level", 16'(level), 16'd4);
    check("ovf_head", 16'(out_data), 16'd1);
    check("ovf_cnt", res_count, STATS ? 16'd4 : 16'd0);
    check("ovf_max", 16'(res_max), STATS ? 16'd4 : 16'd0);

    // Clear racing a drop keeps overflow, then a plain clear releases it.
    clr_ovf = 1'b1; sqrt_valid = 1'b1; sqrt_res = 4'd9; step();
    check("clr_drop_ovf", 16'(overflow), 16'd1);
    check("clr_drop_lvl", 16'(level), 16'd4);
    sqrt_valid = 1'b0; step();
    check("clr_ovf", 16'(overflow), 16'd0);
    clr_ovf = 1'b0;

    // Full with simultaneous pop accepts the push.
    sqrt_valid = 1'b1; sqrt_res = 4'd7; out_ready = 1'b1; step();
    sqrt_valid = 1'b0;
    check("fullpp_level", 16'(level), 16'd4);
    check("fullpp_ovf", 16'(overflow), 16'd0);
    check("fullpp_cnt", res_count, STATS ? 16'd5 : 16'd0);
    check("drain_2", 16'(out_data), 16'd2); step();
    check("drain_3", 16'(out_data), 16'd3); step();
    check("drain_4", 16'(out_data), 16'd4); step();
    check("drain_7", 16'(out_data), 16'd7); step();
    check("drain_empty", 16'(level), 16'd0);

    // Empty: push and ready together must not pop in the same cycle.
    sqrt_valid = 1'b1; sqrt_res = 4'd15; step();
    sqrt_valid = 1'b0; out_ready = 1'b0;
    check("emptypp_level", 16'(level), 16'd1);
    check("emptypp_data", 16'(out_data), 16'd15);
    check("emptypp_max", 16'(res_max), STATS ? 16'd15 : 16'd0);

    // Level 3 then asynchronous reset between edges.
    sqrt_valid = 1'b1; sqrt_res = 4'd5; step();
    sqrt_res = 4'd6; step();
    sqrt_valid = 1'b0;
    check("pre_rst_level", 16'(level), 16'd3);
    #2; reset = 1'b0; #1;
    check("arst_valid", 16'(out_valid), 16'd0);
    check("arst_level", 16'(level), 16'd0);
    check("arst_ovf", 16'(overflow), 16'd0);
    check("arst_cnt", res_count, 16'd0);
    check("arst_max", 16'(res_max), 16'd0);
    step();
    reset = 1'b1;

    // First edge after reset accepts; pop on empty is ignored.
    sqrt_valid = 1'b1; sqrt_res = 4'd8; step();
    sqrt_valid = 1'b0;
    check("first_push_lvl", 16'(level), 16'd1);
    check("first_push_data", 16'(out_data), 16'd8);
    out_ready = 1'b1; step(); step();
    check("empty_pop_lvl", 16'(level), 16'd0);
    out_ready = 1'b0;
    sqrt_valid = 1'b1; sqrt_res = 4'd5; step();
    sqrt_valid = 1'b0;
    check("after_empty_pop", 16'(out_data), 16'd5);
    check("after_empty_lvl", 16'(level), 16'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sqrt_res_collector.md
SQRT_RES_COLLECTOR -- requirements
Module: sqrt_res_collector

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, number of buffered results; power of two, 2..16.
REQ-002 The block SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-003 The block SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 The block SHALL have port sqrt_valid  input  1  one-cycle strobe from sqrt_conv: sqrt_res is valid.
REQ-005 The block SHALL have port sqrt_res  input  4  square-root result from sqrt_conv.
REQ-006 The block SHALL have port out_valid  output  1  head entry available to consumer.
REQ-007 The block SHALL have port out_data  output  4  head entry value.
REQ-008 The block SHALL have port out_ready  input  1  consumer accepts head when high with out_valid.
REQ-009 The block SHALL have port level  output  $clog2(DEPTH+1)  current occupancy.
REQ-010 The block SHALL have port overflow  output  1  sticky: a result was dropped.
REQ-011 The block SHALL have port clr_ovf  input  1  synchronous clear of overflow.
REQ-012 The block SHALL have port res_count  output  16  accepted-result counter (stats feature).
REQ-013 The block SHALL have port res_max  output  4  largest accepted result (stats feature).

Function
REQ-014 Push: sqrt_valid=1 and (level<DEPTH or pop in same cycle) SHALL write sqrt_res at tail, tail advances modulo DEPTH.
REQ-015 Pop: out_valid=1 and out_ready=1 SHALL advance head modulo DEPTH.
REQ-016 out_valid SHALL equal (level!=0); out_data SHALL be the head entry, held stable while out_valid=1 and out_ready=0.
REQ-017 Latency SHALL be 1 cycle: a result pushed at edge N is visible on out_valid/out_data after edge N; no combinational bypass.
REQ-018 Simultaneous push and pop SHALL leave level unchanged, including when full (push accepted) and when level=1.
REQ-019 Push when full with no pop SHALL drop the result, leave FIFO contents unchanged, and set overflow at that edge.
REQ-020 overflow SHALL stay set until clr_ovf=1; if clr_ovf and a drop occur in the same cycle, overflow SHALL remain 1.
REQ-021 Pop when empty SHALL be ignored; pointers and level unchanged.
REQ-022 sqrt_res SHALL be ignored when sqrt_valid=0; no backpressure is presented to sqrt_conv.

Reset
REQ-023 On reset=0 asynchronously: head, tail, level=0; out_valid=0; out_data=0; overflow=0; res_count=0; res_max=0.
REQ-024 Reset mid-operation SHALL discard all buffered entries; storage contents need not be cleared.
REQ-025 The first push SHALL be accepted at the first rising edge after reset deasserts.

Configuration
REQ-026 Macro SQRT_RES_STATS_EN SHALL compile in statistics logic.
REQ-027 With SQRT_RES_STATS_EN: each accepted push SHALL increment res_count, saturating at 16'hFFFF, and update res_max=max(res_max,sqrt_res); dropped results SHALL not count.
REQ-028 Without SQRT_RES_STATS_EN: res_count and res_max ports SHALL remain and be tied to 0; no stats registers instantiated.

Structure
REQ-029 Package sqrt_pkg SHALL hold ARG_W=8, RES_W=4, typedefs arg_t and res_t, and the default DEPTH constant, shared with sqrt_conv.
REQ-030 Storage and pointers SHALL be a sub-module sqrt_res_ring (write port, read port, head/tail/level); the top adds overflow, stats and handshake.

Verification
REQ-031 Reset, push 9 then 4 with out_ready=0 -> level=2, out_data=3, out_valid=1; raise out_ready 2 cycles -> outputs 3 then 2, level=0.
REQ-032 DEPTH=4, push 1,2,3,4 then 5 with out_ready=0 -> overflow=1, level=4, drain order 1,2,3,4; res_count=4 (stats on).
REQ-033 Full FIFO, sqrt_valid=1 value 7 with out_ready=1 -> push accepted, level stays 4, overflow stays 0, 7 drained last.
REQ-034 Empty FIFO, sqrt_valid=1 value 15 and out_ready=1 same cycle -> no pop that cycle, level=1 next cycle, res_max=15.
REQ-035 level=3, assert reset for 1 cycle mid-stream -> out_valid=0, level=0, overflow=0, res_count=0 immediately (asynchronously).
REQ-036 overflow=1, clr_ovf=1 with a simultaneous drop -> overflow=1; next cycle clr_ovf=1 without drop -> overflow=0.
